axi_lite_cfg_sequencer: RTL and testbench
=========================================

Name: axi_lite_cfg_sequencer

Overview:
- AXI4-Lite master that programs the encoder IP's S00_AXI register bank. On `start` it writes NUM_REGS configuration words to consecutive word addresses from BASE_ADDR.
- It then reads every register back and compares it against the written value.
- It reports completion, a response/compare error, and the index of the first failing register.
- It sits between the system control logic and the encoder's AXI4-Lite slave port, replacing software/BFM-driven bring-up.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- NUM_REGS, 4, number of registers to program and verify (1..16).
- BASE_ADDR, 32'h0000_0000, byte address of register 0; register i is at BASE_ADDR + 4*i.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request; ignored while busy=1.
- cfg_data  in  NUM_REGS*32  word i is bits [32*i+31:32*i]; sampled only on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sequence ends, pass or fail.
- error  out  1  sticky; cleared on the next accepted start.
- err_index  out  4  index of the first failing register; valid when error=1.
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset (ARESETN=0, asynchronous) clears everything to 0: state=IDLE, busy, done, error, err_index, all VALID/READY outputs, addresses, WDATA, index counter. Reset mid-transaction abandons the transfer with no cleanup.
- All outputs are registered.

State machine:
- IDLE: start=1 latches cfg_data, clears error/err_index, sets idx=0 and busy=1, then goes to WR.
- WR:
  - Entry asserts AWVALID and WVALID in the same cycle, with AWADDR=BASE_ADDR+4*idx and WDATA=word idx.
  - Each VALID drops on its own handshake (VALID&READY); AW and W may complete in either order or the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - BREADY=1. On BVALID:
    - BRESP≠2'b00: error=1, err_index=idx, go to FIN; no reads are issued.
    - idx==NUM_REGS-1: idx=0, go to RD.
    - Otherwise: idx+1, go to WR.
- RD: ARVALID=1 with ARADDR=BASE_ADDR+4*idx; on ARREADY go to RD_DATA.
- RD_DATA:
  - RREADY=1. On RVALID:
    - RRESP≠OKAY or RDATA≠word idx: error=1, err_index=idx, go to FIN.
    - idx==NUM_REGS-1: go to FIN.
    - Otherwise: idx+1, go to RD.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.

Rules and boundaries:
- Only one outstanding transaction at a time; no write/read overlap.
- VALID, once asserted, holds with stable address/data until its handshake (AXI rule).
- Minimum latency per register, zero-wait slave: write 2 cycles (WR, WR_RESP), read 2 cycles (RD, RD_DATA). For NUM_REGS=4, start to done is 18 cycles.
- A start arriving in the FIN cycle is ignored; the next start is accepted in IDLE.
- Addresses wrap modulo 2^C_M_AXI_ADDR_WIDTH.

Decomposition:
- Package axi_lite_cfg_pkg holds:
  - the state enum (IDLE, WR, WR_RESP, RD, RD_DATA, FIN);
  - constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the AXI prot constant.
- No sub-module. The FSM plus the index counter is about 200 lines.

Test Plan:
- Zero-wait memory slave, cfg_data={4,3,2,1}, start -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then 4 matching reads; done pulses 18 cycles after start; error=0.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 3 cycles with stable AWADDR; exactly one AW and one W per register; sequence passes.
- Slave returns BRESP=SLVERR on the write to 0x8 -> error=1, err_index=2, done pulses, no AR issued, register 3 not written.
- Slave corrupts the readback of 0xC to 0xDEAD -> error=1, err_index=3, done pulse; a new start clears error.
- start pulsed while busy, and again in the FIN cycle -> both ignored; exactly one sequence runs.
- ARESETN driven low mid-WR with AWVALID=1 -> all outputs 0 immediately (asynchronous); after release and a new start, the sequence completes cleanly.

Source files
------------

// File: rtl/axi_lite_cfg_pkg.sv
// Shared state encoding and AXI4-Lite constants for the register-bank
// configuration sequencer.
package axi_lite_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_DATA,
    FIN
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] AXI_PROT    = 3'b000;

endpackage

// File: rtl/axi_lite_cfg_sequencer.sv
// AXI4-Lite master: writes NUM_REGS configuration words from BASE_ADDR upward,
// reads them all back, and reports pass/fail plus the first failing index.
module axi_lite_cfg_sequencer
  import axi_lite_cfg_pkg::*;
#(
  parameter int                              C_M_AXI_ADDR_WIDTH = 32,
  parameter int                              C_M_AXI_DATA_WIDTH = 32,
  parameter int                              NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic                                   start,
  input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [3:0]                             err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                             M_AXI_AWPROT,
  output logic                                   M_AXI_AWVALID,
  input  logic                                   M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [3:0]                             M_AXI_WSTRB,
  output logic                                   M_AXI_WVALID,
  input  logic                                   M_AXI_WREADY,
  input  logic [1:0]                             M_AXI_BRESP,
  input  logic                                   M_AXI_BVALID,
  output logic                                   M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                             M_AXI_ARPROT,
  output logic                                   M_AXI_ARVALID,
  input  logic                                   M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                             M_AXI_RRESP,
  input  logic                                   M_AXI_RVALID,
  output logic                                   M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_e                 state_q,   state_d;
  logic [3:0]             idx_q,     idx_d;
  logic [NUM_REGS*DW-1:0] cfg_q,     cfg_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;
  logic                   error_q,   error_d;
  logic [3:0]             erridx_q,  erridx_d;
  logic [AW-1:0]          awaddr_q,  awaddr_d;
  logic                   awvalid_q, awvalid_d;
  logic [DW-1:0]          wdata_q,   wdata_d;
  logic                   wvalid_q,  wvalid_d;
  logic                   bready_q,  bready_d;
  logic [AW-1:0]          araddr_q,  araddr_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q,  rready_d;

  logic aw_done, w_done;

  function automatic logic [AW-1:0] addr_of(input logic [3:0] i);
    return BASE_ADDR + AW'({i, 2'b00});
  endfunction

  // Mux with constant slice indices so the select width never depends on NUM_REGS.
  function automatic logic [DW-1:0] word_of(input logic [NUM_REGS*DW-1:0] cfg,
                                            input logic [3:0]             i);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (i == 4'(k)) w = cfg[DW*k +: DW];
    end
    return w;
  endfunction

  // A channel counts as finished once its VALID has dropped or is accepted now.
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q  || M_AXI_WREADY;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cfg_d     = cfg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    erridx_d  = erridx_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d     = cfg_data;
          error_d   = 1'b0;
          erridx_d  = 4'd0;
          idx_d     = 4'd0;
          busy_d    = 1'b1;
          awaddr_d  = addr_of(4'd0);
          wdata_d   = word_of(cfg_data, 4'd0);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR;
        end
      end
      WR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) begin
            error_d  = 1'b1;
            erridx_d = idx_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = FIN;
          end else if (idx_q == LAST_IDX) begin
            idx_d     = 4'd0;
            araddr_d  = addr_of(4'd0);
            arvalid_d = 1'b1;
            state_d   = RD;
          end else begin
            idx_d     = idx_q + 4'd1;
            awaddr_d  = addr_of(idx_q + 4'd1);
            wdata_d   = word_of(cfg_q, idx_q + 4'd1);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end
        end
      end
      RD: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (M_AXI_RRESP != RESP_OKAY || M_AXI_RDATA != word_of(cfg_q, idx_q)) begin
            error_d  = 1'b1;
            erridx_d = idx_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = FIN;
          end else if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            idx_d     = idx_q + 4'd1;
            araddr_d  = addr_of(idx_q + 4'd1);
            arvalid_d = 1'b1;
            state_d   = RD;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cfg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      erridx_q  <= '0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cfg_q     <= cfg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      erridx_q  <= erridx_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_index     = erridx_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = AXI_PROT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = AXI_PROT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cfg_sequencer.sv
// Bench for axi_lite_cfg_sequencer: memory-like AXI4-Lite slave with tunable
// ready latency and fault injection, plus a queue-based transaction scoreboard.
module tb_axi_lite_cfg_sequencer;
  import axi_lite_cfg_pkg::*;

  localparam int          NREG = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic              start;
  logic [NREG*32-1:0] cfg_data;
  logic              busy, done, error;
  logic [3:0]        err_index;
  logic [31:0]       M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]        M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]        M_AXI_WSTRB;
  logic              M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic              M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic              M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]        M_AXI_BRESP, M_AXI_RRESP;

  always #5 ACLK = ~ACLK;

  axi_lite_cfg_sequencer #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(NREG), .BASE_ADDR(BASE)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int start_cyc = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave model: READY rises once VALID has waited *_lat cycles; B/R come one cycle later.
  int aw_lat = 0, w_lat = 0, ar_lat = 0;
  int aw_cnt, w_cnt, ar_cnt;
  int bad_b = -1, bad_r = -1;
  bit bad_r_resp = 1'b0;
  logic        aw_got, w_got;
  logic [31:0] awaddr_l, wdata_l;
  logic [31:0] mem [16];

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_lat);
  assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_lat);
  assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_lat);

  wire        aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  wire        w_hs    = M_AXI_WVALID  && M_AXI_WREADY;
  wire        ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
  wire        b_hs    = M_AXI_BVALID  && M_AXI_BREADY;
  wire        r_hs    = M_AXI_RVALID  && M_AXI_RREADY;
  wire [31:0] wr_addr = aw_hs ? M_AXI_AWADDR : awaddr_l;
  wire [31:0] wr_data = w_hs  ? M_AXI_WDATA  : wdata_l;
  wire        wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
  wire [3:0]  wr_slot = wr_addr[5:2];
  wire [3:0]  rd_slot = M_AXI_ARADDR[5:2];

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      awaddr_l <= '0; wdata_l <= '0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
    end else begin
      aw_cnt <= aw_hs ? 0 : (M_AXI_AWVALID ? aw_cnt + 1 : 0);
      w_cnt  <= w_hs  ? 0 : (M_AXI_WVALID  ? w_cnt + 1  : 0);
      ar_cnt <= ar_hs ? 0 : (M_AXI_ARVALID ? ar_cnt + 1 : 0);
      if (b_hs) M_AXI_BVALID <= 1'b0;
      if (wr_fire) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        M_AXI_BVALID <= 1'b1;
        if (int'(wr_slot) == bad_b) begin
          M_AXI_BRESP <= RESP_SLVERR;
        end else begin
          M_AXI_BRESP <= RESP_OKAY;
          mem[wr_slot] <= wr_data;
        end
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; awaddr_l <= M_AXI_AWADDR; end
        if (w_hs)  begin w_got  <= 1'b1; wdata_l  <= M_AXI_WDATA;  end
      end
      if (r_hs) M_AXI_RVALID <= 1'b0;
      if (ar_hs) begin
        M_AXI_RVALID <= 1'b1;
        if (int'(rd_slot) == bad_r && bad_r_resp) begin
          M_AXI_RRESP <= RESP_SLVERR; M_AXI_RDATA <= mem[rd_slot];
        end else if (int'(rd_slot) == bad_r) begin
          M_AXI_RRESP <= RESP_OKAY;   M_AXI_RDATA <= 32'hDEAD;
        end else begin
          M_AXI_RRESP <= RESP_OKAY;   M_AXI_RDATA <= mem[rd_slot];
        end
      end
    end
  end

  // Scoreboard queues filled by the reference model when a sequence is launched.
  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  logic [4:0]  exp_done[$];
  int          exp_lat[$];
  logic [31:0] wv [NREG];

  // Reference: write every word in order, stop at the first bad write response;
  // otherwise read every word back, stop at the first bad readback.
  task automatic push_model(input int bb, input int br);
    for (int i = 0; i < NREG; i++) begin
      exp_aw.push_back(BASE + 32'(4 * i));
      exp_w.push_back(wv[i]);
      if (i == bb) begin exp_done.push_back({1'b1, 4'(i)}); return; end
    end
    for (int i = 0; i < NREG; i++) begin
      exp_ar.push_back(BASE + 32'(4 * i));
      if (i == br) begin exp_done.push_back({1'b1, 4'(i)}); return; end
    end
    exp_done.push_back(5'b0);
  endtask

  task automatic flush_queues();
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_done.delete(); exp_lat.delete();
  endtask

  // Monitor: handshakes are judged at the negedge before the posedge that completes them.
  initial begin
    logic aw_pend, w_pend, ar_pend, prev_done;
    logic [31:0] p_aw, p_w, p_ar;
    logic [4:0] ed;
    int el;
    aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0; prev_done = 1'b0;
    p_aw = '0; p_w = '0; p_ar = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0; prev_done = 1'b0;
      end else begin
        if (aw_pend) begin
          chk("AWVALID held until ready", 64'(M_AXI_AWVALID), 64'(1));
          chk("AWADDR stable while waiting", 64'(M_AXI_AWADDR), 64'(p_aw));
        end
        if (w_pend) begin
          chk("WVALID held until ready", 64'(M_AXI_WVALID), 64'(1));
          chk("WDATA stable while waiting", 64'(M_AXI_WDATA), 64'(p_w));
        end
        if (ar_pend) begin
          chk("ARVALID held until ready", 64'(M_AXI_ARVALID), 64'(1));
          chk("ARADDR stable while waiting", 64'(M_AXI_ARADDR), 64'(p_ar));
        end
        if (aw_hs) begin
          chk("AW transfer expected", 64'(exp_aw.size() != 0), 64'(1));
          if (exp_aw.size() != 0) chk("AWADDR", 64'(M_AXI_AWADDR), 64'(exp_aw.pop_front()));
        end
        if (w_hs) begin
          chk("W transfer expected", 64'(exp_w.size() != 0), 64'(1));
          if (exp_w.size() != 0) chk("WDATA", 64'(M_AXI_WDATA), 64'(exp_w.pop_front()));
        end
        if (ar_hs) begin
          chk("AR transfer expected", 64'(exp_ar.size() != 0), 64'(1));
          if (exp_ar.size() != 0) chk("ARADDR", 64'(M_AXI_ARADDR), 64'(exp_ar.pop_front()));
        end
        if (prev_done) chk("done lasts one cycle", 64'(done), 64'(0));
        if (done) begin
          chk("done expected", 64'(exp_done.size() != 0), 64'(1));
          if (exp_done.size() != 0) begin
            ed = exp_done.pop_front();
            el = exp_lat.pop_front();
            chk("error at done", 64'(error), 64'(ed[4]));
            chk("err_index at done", 64'(err_index), 64'(ed[3:0]));
            if (el >= 0) chk("start-to-done latency", 64'(cyc - start_cyc), 64'(el));
          end
          chk("busy low during done", 64'(busy), 64'(0));
        end
        aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY; p_aw = M_AXI_AWADDR;
        w_pend  = M_AXI_WVALID  && !M_AXI_WREADY;  p_w  = M_AXI_WDATA;
        ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY; p_ar = M_AXI_ARADDR;
        prev_done = done;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, " control outputs"},
        64'({busy, done, error, err_index, M_AXI_AWVALID, M_AXI_WVALID,
             M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
    chk({tag, " AWADDR"}, 64'(M_AXI_AWADDR), 64'(0));
    chk({tag, " WDATA"},  64'(M_AXI_WDATA),  64'(0));
    chk({tag, " ARADDR"}, 64'(M_AXI_ARADDR), 64'(0));
  endtask

  task automatic load_cfg();
    for (int i = 0; i < NREG; i++) cfg_data[32*i +: 32] = wv[i];
  endtask

  task automatic run_seq(input int bb, input int br, input bit br_resp,
                         input bit zero_wait, input bit busy_start, input bit fin_start);
    int t;
    bad_b = bb; bad_r = br; bad_r_resp = br_resp;
    load_cfg();
    push_model(bb, br);
    // 17 edges after the start cycle = 18 cycles counting both start and done cycles.
    exp_lat.push_back(zero_wait ? 17 : -1);
    @(posedge ACLK); #1;
    start = 1'b1; start_cyc = cyc;
    @(posedge ACLK); #1;
    start = 1'b0;
    cfg_data = ~cfg_data;
    @(negedge ACLK);
    chk("busy after accepted start", 64'(busy), 64'(1));
    chk("error cleared by start", 64'(error), 64'(0));
    chk("err_index cleared by start", 64'(err_index), 64'(0));
    if (busy_start) begin
      repeat (2) @(posedge ACLK);
      #1 start = 1'b1;
      @(posedge ACLK);
      #1 start = 1'b0;
    end
    t = 0;
    while (!done && t < 3000) begin
      @(negedge ACLK);
      t++;
    end
    chk("sequence finished before timeout", 64'(done), 64'(1));
    if (fin_start) begin
      start = 1'b1;
      @(posedge ACLK);
      #1 start = 1'b0;
      @(negedge ACLK);
      chk("start in done cycle ignored (busy)", 64'(busy), 64'(0));
      chk("start in done cycle ignored (AWVALID)", 64'(M_AXI_AWVALID), 64'(0));
    end
    repeat (2) @(negedge ACLK);
    chk("no outstanding expected transfers",
        64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_done.size()), 64'(0));
    chk("error sticky after done", 64'(error), 64'((bb >= 0) || (br >= 0)));
  endtask

  initial begin
    int t, kind;
    ARESETN = 1'b0; start = 1'b0; cfg_data = '0;
    repeat (3) @(posedge ACLK);
    #1 check_all_zero("in reset");
    chk("AWPROT", 64'(M_AXI_AWPROT), 64'(0));
    chk("ARPROT", 64'(M_AXI_ARPROT), 64'(0));
    chk("WSTRB",  64'(M_AXI_WSTRB),  64'(4'hF));
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_all_zero("idle after reset");

    // Zero-wait pass with words 1..4.
    for (int i = 0; i < NREG; i++) wv[i] = 32'(i + 1);
    run_seq(-1, -1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Slow AW, immediate W.
    aw_lat = 2;
    for (int i = 0; i < NREG; i++) wv[i] = $urandom;
    run_seq(-1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    aw_lat = 0;

    // Write error on register 2: no reads, register 3 never written.
    run_seq(2, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Corrupted readback of register 3, then a clean run clears error.
    for (int i = 0; i < NREG; i++) wv[i] = 32'h1000 + 32'(i);
    run_seq(-1, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Starts while busy and during the done cycle are ignored.
    for (int i = 0; i < NREG; i++) wv[i] = $urandom;
    run_seq(-1, -1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset while AWVALID is waiting for ready.
    aw_lat = 3;
    for (int i = 0; i < NREG; i++) wv[i] = $urandom;
    load_cfg();
    push_model(-1, -1);
    exp_lat.push_back(-1);
    @(posedge ACLK); #1 start = 1'b1;
    @(posedge ACLK); #1 start = 1'b0;
    t = 0;
    while (!M_AXI_AWVALID && t < 20) begin @(posedge ACLK); #1; t++; end
    chk("AWVALID up before reset", 64'(M_AXI_AWVALID), 64'(1));
    #2 ARESETN = 1'b0;
    #1 check_all_zero("async reset mid-write");
    flush_queues();
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    aw_lat = 0;
    for (int i = 0; i < NREG; i++) wv[i] = $urandom;
    run_seq(-1, -1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized latencies and fault injection.
    for (int r = 0; r < 10; r++) begin
      aw_lat = $urandom_range(0, 3);
      w_lat  = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3);
      for (int i = 0; i < NREG; i++) begin
        wv[i] = $urandom;
        if (wv[i] == 32'hDEAD) wv[i] = 32'h1;
      end
      kind = $urandom_range(0, 3);
      case (kind)
        1:       run_seq($urandom_range(0, NREG - 1), -1, 1'b0, 1'b0, 1'b0, 1'b0);
        2:       run_seq(-1, $urandom_range(0, NREG - 1), 1'b0, 1'b0, 1'b0, 1'b0);
        3:       run_seq(-1, $urandom_range(0, NREG - 1), 1'b1, 1'b0, 1'b0, 1'b0);
        default: run_seq(-1, -1, 1'b0, (aw_lat == 0) && (w_lat == 0) && (ar_lat == 0),
                         1'b0, 1'b0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
